// File: rtl/ex_div_seq_pkg.sv
// Shared state codes, handshake constants and helpers for the EX-stage sequential divider.
package ex_div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [5:0] DivIters = 6'd32;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational 33-bit trial subtractor; bit 32 of the difference set means "does not fit".
module div_trial_sub
  import ex_div_seq_pkg::*;
(
  input  logic [31:0] i_rem,
  input  logic [31:0] i_divisor,
  output logic [32:0] o_diff
);

  assign o_diff = {1'b0, i_rem} - {1'b0, i_divisor};

endmodule

// File: rtl/ex_div_seq.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU) raising a pipeline stall while busy.
// Define DIV_SIGNED_EN to honor signed_div_i; otherwise every operation is DIVU.
module ex_div_seq
  import ex_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_dividend;
  logic [31:0] r_divisor;
  logic [63:0] r_result;
  logic        r_ready;

  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;
  logic [32:0] w_trial;

`ifdef DIV_SIGNED_EN
  logic r_signed;
  logic r_op1_neg;
  logic r_op2_neg;

  assign w_op1_mag  = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
  assign w_op2_mag  = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
  assign w_quot_fix = (r_signed && (r_op1_neg ^ r_op2_neg)) ? neg32(r_dividend[31:0])
                                                              : r_dividend[31:0];
  // Remainder takes the dividend's sign.
  assign w_rem_fix  = (r_signed && r_op1_neg) ? neg32(r_dividend[64:33]) : r_dividend[64:33];
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_div_i;
  assign w_op1_mag       = opdata1_i;
  assign w_op2_mag       = opdata2_i;
  assign w_quot_fix      = r_dividend[31:0];
  assign w_rem_fix       = r_dividend[64:33];
`endif

  div_trial_sub u_trial (
    .i_rem     (r_dividend[63:32]),
    .i_divisor (r_divisor),
    .o_diff    (w_trial)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= DivFree;
      r_cnt      <= 6'd0;
      r_dividend <= 65'd0;
      r_divisor  <= 32'd0;
      r_result   <= 64'd0;
      r_ready    <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      r_signed   <= 1'b0;
      r_op1_neg  <= 1'b0;
      r_op2_neg  <= 1'b0;
`endif
    end else begin
      case (r_state)
        DivFree: begin
          r_result <= 64'd0;
          r_ready  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              r_state <= DivByZero;
            end else begin
              r_state    <= DivOn;
              r_cnt      <= 6'd0;
              r_dividend <= {32'd0, w_op1_mag, 1'b0};
              r_divisor  <= w_op2_mag;
`ifdef DIV_SIGNED_EN
              r_signed   <= signed_div_i;
              r_op1_neg  <= opdata1_i[31];
              r_op2_neg  <= opdata2_i[31];
`endif
            end
          end
        end
        DivByZero: begin
          r_dividend <= 65'd0;
          r_result   <= 64'd0;
          r_ready    <= DivResultReady;
          r_state    <= DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            r_state <= DivFree;
            r_cnt   <= 6'd0;
          end else if (r_cnt != DivIters) begin
            if (w_trial[32]) begin
              r_dividend <= r_dividend << 1;
            end else begin
              r_dividend <= {w_trial[31:0], r_dividend[31:0], 1'b1};
            end
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= DivResultReady;
            r_state  <= DivEnd;
            r_cnt    <= 6'd0;
          end
        end
        DivEnd: begin
          if (start_i == DivStop || annul_i) begin
            r_state  <= DivFree;
            r_result <= 64'd0;
            r_ready  <= DivResultNotReady;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = rst & start_i & ~annul_i & ~r_ready;

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed self-checking bench for ex_div_seq; expectations follow DIV_SIGNED_EN when defined.
module tb_ex_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int total;
  int bad;

  ex_div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a division and runs until ready (or a 100-edge budget); leaves start_i high.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output int stalls, output logic [63:0] res);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    edges      = 0;
    stalls     = 0;
    #1;
    if (stallreq) stalls++;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        edges = k + 1;
        break;
      end
      if (stallreq) stalls++;
    end
    res = result;
  endtask

  task automatic release_div();
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    #1;
    total++;
    if (stallreq !== 1'b0) begin
      bad++;
      $display("FAIL reset_stallreq got=%b want=0", stallreq);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0", ready);
    end
    total++;
    if (result !== 64'd0) begin
      bad++;
      $display("FAIL reset_result got=%h want=0", result);
    end
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_basic();
    int e, s;
    logic [63:0] r;
    run_div(1'b0, 32'd100, 32'd7, e, s, r);
    total++;
    if (e != 34) begin
      bad++;
      $display("FAIL divu_latency got=%0d want=34", e);
    end
    total++;
    if (s != 34) begin
      bad++;
      $display("FAIL divu_stall_cycles got=%0d want=34", s);
    end
    total++;
    if (r !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL divu_result got=%h want=%h", r, {32'd2, 32'd14});
    end
    total++;
    if (stallreq !== 1'b0) begin
      bad++;
      $display("FAIL divu_stall_at_ready got=%b want=0", stallreq);
    end
    @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL end_hold got=%b/%h want=1/%h", ready, result, {32'd2, 32'd14});
    end
    release_div();
    total++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      bad++;
      $display("FAIL end_exit got=%b/%h want=0/0", ready, result);
    end
  endtask

  task automatic test_signed();
    int e, s;
    logic [63:0] r;
    logic [63:0] exp_a, exp_b;
`ifdef DIV_SIGNED_EN
    exp_a = {32'hFFFFFFFF, 32'hFFFFFFFD};
    exp_b = {32'h00000001, 32'hFFFFFFFD};
`else
    exp_a = {32'h00000001, 32'h7FFFFFFC};
    exp_b = {32'h00000007, 32'h00000000};
`endif
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, e, s, r);
    release_div();
    total++;
    if (r !== exp_a || e != 34) begin
      bad++;
      $display("FAIL div_neg7_by_2 got=%h/%0d want=%h/34", r, e, exp_a);
    end
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, e, s, r);
    release_div();
    total++;
    if (r !== exp_b || e != 34) begin
      bad++;
      $display("FAIL div_7_by_neg2 got=%h/%0d want=%h/34", r, e, exp_b);
    end
  endtask

  task automatic test_div_by_zero();
    int e, s;
    logic [63:0] r;
    run_div(1'b0, 32'hFFFFFFFF, 32'd0, e, s, r);
    release_div();
    total++;
    if (e != 2) begin
      bad++;
      $display("FAIL divzero_latency got=%0d want=2", e);
    end
    total++;
    if (s != 2) begin
      bad++;
      $display("FAIL divzero_stall_cycles got=%0d want=2", s);
    end
    total++;
    if (r !== 64'd0) begin
      bad++;
      $display("FAIL divzero_result got=%h want=0", r);
    end
  endtask

  task automatic test_boundaries();
    int e, s;
    logic [63:0] r;
    logic [63:0] exp_min;
`ifdef DIV_SIGNED_EN
    exp_min = {32'h00000000, 32'h80000000};
`else
    exp_min = {32'h80000000, 32'h00000000};
`endif
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, e, s, r);
    release_div();
    total++;
    if (r !== exp_min) begin
      bad++;
      $display("FAIL div_min_by_neg1 got=%h want=%h", r, exp_min);
    end
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, e, s, r);
    release_div();
    total++;
    if (r !== {32'd0, 32'hFFFFFFFF}) begin
      bad++;
      $display("FAIL divu_max_by_1 got=%h want=%h", r, {32'd0, 32'hFFFFFFFF});
    end
  endtask

  task automatic test_annul();
    int e, s, hits;
    logic [63:0] r;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1;
    #1;
    total++;
    if (stallreq !== 1'b0) begin
      bad++;
      $display("FAIL annul_stall_drop got=%b want=0", stallreq);
    end
    @(posedge clk);
    #1;
    annul = 1'b0;
    start = 1'b0;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready) hits++;
      @(posedge clk);
      #1;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL annul_no_ready got=%0d want=0", hits);
    end
    run_div(1'b0, 32'd1000, 32'd9, e, s, r);
    release_div();
    total++;
    if (e != 34 || r !== {32'd1, 32'd111}) begin
      bad++;
      $display("FAIL annul_restart got=%h/%0d want=%h/34", r, e, {32'd1, 32'd111});
    end
  endtask

  task automatic test_reset_mid();
    int e;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (stallreq !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_stall got=%b want=0", stallreq);
    end
    @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b/%h want=0/0", ready, result);
    end
    rst = 1'b1;
    e = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        e = k + 1;
        break;
      end
    end
    total++;
    if (e != 34 || result !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL rstmid_restart got=%h/%0d want=%h/34", result, e, {32'd2, 32'd14});
    end
    release_div();
  endtask

  task automatic test_back_to_back();
    int e1, e2, s;
    logic [63:0] r1, r2;
    run_div(1'b0, 32'd50, 32'd5, e1, s, r1);
    release_div();
    run_div(1'b0, 32'd51, 32'd5, e2, s, r2);
    release_div();
    total++;
    if (r1 !== {32'd0, 32'd10} || e1 != 34) begin
      bad++;
      $display("FAIL b2b_first got=%h/%0d want=%h/34", r1, e1, {32'd0, 32'd10});
    end
    total++;
    if (r2 !== {32'd1, 32'd10} || e2 != 34) begin
      bad++;
      $display("FAIL b2b_second got=%h/%0d want=%h/34", r2, e2, {32'd1, 32'd10});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_boundaries();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Sequential 32-bit radix-2 restoring divider for the EX stage, serving DIV/DIVU. It is the requesting end of the pipeline stall protocol: while a division is in flight it raises `stallreq_o`, which EX forwards to the stall controller as `stall_from_ex`. The controller answers with a freeze of PC/IF/ID/EX (`stall = 6'b001111`). When the result is ready the request drops and the 64-bit {remainder, quotient} is handed to EX for the HI/LO writeback.

## Interface
Parameters: none (width fixed at 32).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous and active-low
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; held high by EX until `ready_o` is observed
- `annul_i`  in  1  abort (flush/exception); wins over `start_i`
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; valid only while `ready_o` = 1
- `ready_o`  out  1  result valid
- `stallreq_o`  out  1  combinational: `start_i & ~annul_i & ~ready_o`; forced 0 while `rst` = 0

## Operation
- **Reset** (`rst` = 0 at an edge):
  - state FREE; `cnt` = 0; dividend register = 0
  - `result_o` = 0; `ready_o` = 0
- **FREE**
  - `start_i & ~annul_i`, divisor = 0: go to BYZERO.
  - `start_i & ~annul_i`, divisor ≠ 0: go to ON.
    - `cnt` <= 0.
    - Operands latched as magnitudes: a negative operand is two's-complemented when signed.
    - Dividend register (65 bits) <= {32'b0, |op1|, 1'b0}.
    - Raw sign flags of op1/op2 latched.
  - Otherwise: stay in FREE; `result_o` = 0; `ready_o` = 0.
- **BYZERO**: dividend register <= 0; go to END.
- **ON**
  - `annul_i` = 1: go to FREE at once; `cnt` cleared; nothing reaches `result_o`.
  - `cnt` ≠ 32, per cycle:
    - `t = {1'b0, R[63:32]} − {1'b0, |divisor|}`.
    - If `t[32]` = 1: `R <= R << 1`.
    - Else: `R <= {t[31:0], R[31:0], 1'b1}`.
    - `cnt++`.
  - `cnt` = 32:
    - Signed and sign(op1) ≠ sign(op2): negate quotient `R[31:0]`.
    - Signed and op1 negative: negate the remainder. The remainder is taken from `R[64:33]`, the 32 bits that sit above the quotient after the final shift.
    - Go to END. `cnt` <= 0.
- **END**
  - `result_o` = {remainder, quotient}; `ready_o` = 1.
  - `start_i` = 0 or `annul_i` = 1: go to FREE next edge; `result_o`/`ready_o` return to 0.
  - Otherwise: hold.
- **Arithmetic**
  - All negation is 32-bit two's complement; wrap is intended.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
  - Divide by zero gives result 0 (architecturally UNPREDICTABLE; fixed here for determinism).
- **`start_i` falling during ON** (without annul): the division completes. END then exits on the next edge.

## Timing
- Start sampled at edge E0 (FREE→ON). Iterations run on E1..E32. E33 takes ON→END. `ready_o` is high from E33 onward: 34 edges, start to result.
- Divide by zero: E0 FREE→BYZERO, E1 BYZERO→END. `ready_o` is high after E1.
- `stallreq_o` is high in the same cycle `start_i` rises (combinational). It falls in the cycle `ready_o` rises. This lets EX's writeback of HI/LO see `ready_o` in an un-stalled cycle.
- Back-to-back: a new division may start only from FREE. One idle edge is required between divisions (END→FREE).
- Reset mid-operation: the next edge with `rst` = 0 forces FREE, zero outputs, and `stallreq_o` = 0 from that edge.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `signed_div_i` is honored.
  - Magnitude conversion and sign correction are present.
- Not defined:
  - `signed_div_i` is ignored and every operation is DIVU.
  - No negation logic is compiled.
  - Latency is unchanged.

## Structure
- Shared constants go in `define.v`:
  - state codes `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11
  - `DivResultReady`/`DivResultNotReady`
  - `DivStart`/`DivStop`
- One sub-module: `div_trial_sub`, a combinational 33-bit trial subtractor returning `t`. Keeps the FSM file readable and unit-testable.

## Test plan
- DIVU 100 / 7 → `ready_o` high after E33; `result_o` = {32'd2, 32'd14}; `stallreq_o` high for exactly 34 cycles.
- DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU 0xFFFFFFFF / 0 → `ready_o` after E1; `result_o` = 0; `stallreq_o` high 2 cycles.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- `annul_i` pulsed at iteration 10 → FREE next edge; `ready_o` never rises; `stallreq_o` drops that cycle. A fresh start then gives a correct result in 34 edges.
- `rst` = 0 at iteration 20 → outputs 0, FREE. `start_i` held through release → the division restarts from E0 and completes correctly.
